// File: rtl/led_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear/toggle strobes and per-bit
// hardware blinking driven by a programmable half-period prescaler.
module led_pio_blink #(
    parameter int unsigned            DATA_WIDTH   = 10,
    parameter int unsigned            PERIOD_WIDTH = 24,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE  = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2:0]             address,
    input  logic                   chipselect,
    input  logic                   write_n,
    input  logic [31:0]            writedata,
    output logic [31:0]            readdata,
    output logic [DATA_WIDTH-1:0]  out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_BLINK  = 3'd4;
    localparam logic [2:0] ADDR_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_OUT    = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    logic [DATA_WIDTH-1:0]   data_q,     data_d;
    logic [DATA_WIDTH-1:0]   blink_en_q, blink_en_d;
    logic [PERIOD_WIDTH-1:0] period_q,   period_d;
    logic [PERIOD_WIDTH-1:0] cnt_q,      cnt_d;
    logic                    phase_q,    phase_d;

    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [31:0]             status;
    logic                    unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wr_data   = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d     = wr_data;
                ADDR_SET:    data_d     = data_q | wr_data;
                ADDR_CLEAR:  data_d     = data_q & ~wr_data;
                ADDR_TOGGLE: data_d     = data_q ^ wr_data;
                ADDR_BLINK:  blink_en_d = wr_data;
                ADDR_PERIOD: period_d   = writedata[PERIOD_WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    // A PERIOD write restarts the engine in the "on" phase, overriding the count.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if ((wr_en && address == ADDR_PERIOD) || period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = period_q - PERIOD_WIDTH'(1);
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b1;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign out_port = data_q & ~(blink_en_q & {DATA_WIDTH{~phase_q}});

    // With a 32-bit counter the top bit is dropped so phase keeps bit 31.
    assign status = {phase_q, 31'(cnt_q)};

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_BLINK:  readdata = 32'(blink_en_q);
            ADDR_PERIOD: readdata = 32'(period_q);
            ADDR_OUT:    readdata = 32'(out_port);
            ADDR_STATUS: readdata = status;
            default:     readdata = '0;
        endcase
    end

endmodule
